// File: rtl/phase_timer.sv
// phase_timer: per-phase countdown for the traffic-light controller. It loads the phase duration
// on a phase change, counts down on a 1 s tick and pulses g/y/r_end on expiry. The PHASE_TIMER_HOLD_EN macro enables the hold input.
module phase_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 7,
    parameter int G_TIME   = 30,
    parameter int Y_TIME   = 3,
    parameter int R_TIME   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fsm_g,
    input  logic             fsm_y,
    input  logic             fsm_r,
    input  logic             hold,
    output logic             g_end,
    output logic             y_end,
    output logic             r_end,
    output logic             tick,
    output logic [CNT_W-1:0] remain,
    output logic [3:0]       remain_tens,
    output logic [3:0]       remain_ones
);

    // state     | meaning
    // S_IDLE    | phase vector not one-hot, nothing to time
    // S_COUNT   | counting the current phase down
    // S_EXPIRED | remain reached 0, waiting for the FSM to change phase
    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_EXPIRED} state_t;

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] G_D = CNT_W'((G_TIME == 0) ? 1 : G_TIME);
    localparam logic [CNT_W-1:0] Y_D = CNT_W'((Y_TIME == 0) ? 1 : Y_TIME);
    localparam logic [CNT_W-1:0] R_D = CNT_W'((R_TIME == 0) ? 1 : R_TIME);

    state_t           state_q;
    logic [2:0]       phase_q;
    logic [CNT_W-1:0] remain_q;
    logic [DIV_W-1:0] div_q;
    logic             g_end_q;
    logic             y_end_q;
    logic             r_end_q;

    logic [2:0]       phase_vec;
    logic             phase_chg;
    logic             vec_onehot;
    logic             hold_eff;
    logic             tick_w;
    logic [31:0]      rem_ext;

`ifdef PHASE_TIMER_HOLD_EN
    assign hold_eff = hold;
`else
    logic unused_hold;
    assign unused_hold = hold;
    assign hold_eff    = 1'b0;
`endif

    assign phase_vec  = {fsm_g, fsm_y, fsm_r};
    assign phase_chg  = (phase_vec != phase_q);
    assign vec_onehot = $onehot(phase_vec);
    assign tick_w     = (state_q == S_COUNT) && (div_q == DIV_LAST) && !hold_eff;

    function automatic logic [CNT_W-1:0] duration(input logic [2:0] v);
        case (v)
            3'b100:  return G_D;
            3'b010:  return Y_D;
            default: return R_D;
        endcase
    endfunction

    // A phase change outranks a coincident tick: the new phase reloads and no end is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= 3'b000;
            remain_q <= '0;
            div_q    <= '0;
            g_end_q  <= 1'b0;
            y_end_q  <= 1'b0;
            r_end_q  <= 1'b0;
        end else begin
            phase_q <= phase_vec;
            g_end_q <= 1'b0;
            y_end_q <= 1'b0;
            r_end_q <= 1'b0;
            if (phase_chg) begin
                div_q <= '0;
                if (vec_onehot) begin
                    remain_q <= duration(phase_vec);
                    state_q  <= S_COUNT;
                end else begin
                    remain_q <= '0;
                    state_q  <= S_IDLE;
                end
            end else if (state_q == S_COUNT && !hold_eff) begin
                if (div_q == DIV_LAST) begin
                    div_q <= '0;
                    if (remain_q > CNT_W'(1)) begin
                        remain_q <= remain_q - CNT_W'(1);
                    end else begin
                        remain_q <= '0;
                        g_end_q  <= phase_q[2];
                        y_end_q  <= phase_q[1];
                        r_end_q  <= phase_q[0];
                        state_q  <= S_EXPIRED;
                    end
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end
        end
    end

    assign rem_ext = 32'(remain_q);

    always_comb begin
        remain_tens = 4'd9;
        remain_ones = 4'd9;
        if (rem_ext <= 32'd99) begin
            remain_tens = 4'(rem_ext / 32'd10);
            remain_ones = 4'(rem_ext % 32'd10);
        end
    end

    assign g_end  = g_end_q;
    assign y_end  = y_end_q;
    assign r_end  = r_end_q;
    assign tick   = tick_w;
    assign remain = remain_q;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: two instances (small durations and BCD/saturation corner values)
// driven through a linear sequence of steps with hand-computed expectations.
module tb_phase_timer;

`ifdef PHASE_TIMER_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, fsm_g, fsm_y, fsm_r, hold;
    logic       g_end, y_end, r_end, tick;
    logic [6:0] remain;
    logic [3:0] tens, ones;

    logic       rst_b, b_g, b_y, b_r;
    logic       b_g_end, b_y_end, b_r_end, b_tick;
    logic [6:0] b_remain;
    logic [3:0] b_tens, b_ones;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         end_cyc[7];
    logic [2:0] end_kind[7];
    int         n_end, multi, phase_idx, held, eff;
    bit         pending;
    logic [2:0] exp_vec;

    phase_timer #(.TICK_DIV(4), .CNT_W(7), .G_TIME(3), .Y_TIME(2), .R_TIME(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .fsm_g(fsm_g), .fsm_y(fsm_y), .fsm_r(fsm_r), .hold(hold),
        .g_end(g_end), .y_end(y_end), .r_end(r_end), .tick(tick), .remain(remain),
        .remain_tens(tens), .remain_ones(ones)
    );

    phase_timer #(.TICK_DIV(4), .CNT_W(7), .G_TIME(45), .Y_TIME(0), .R_TIME(120)) u_bcd (
        .clk(clk), .rst_n(rst_b), .fsm_g(b_g), .fsm_y(b_y), .fsm_r(b_r), .hold(1'b0),
        .g_end(b_g_end), .y_end(b_y_end), .r_end(b_r_end), .tick(b_tick), .remain(b_remain),
        .remain_tens(b_tens), .remain_ones(b_ones)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic [2:0] v);
        {fsm_g, fsm_y, fsm_r} = v;
    endtask

    function automatic logic [2:0] loop_vec(input int idx);
        case (idx % 3)
            0:       return 3'b001;
            1:       return 3'b100;
            default: return 3'b010;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; rst_b = 1'b0; hold = 1'b0;
        set_vec(3'b000);
        {b_g, b_y, b_r} = 3'b000;
        repeat (2) step();
        chk("rst_remain", remain, 0);
        chk("rst_ends", {g_end, y_end, r_end}, 0);
        chk("rst_tick", tick, 0);
        chk("rst_bcd", {tens, ones}, 0);

        // red present at reset release: first valid phase counts as a change
        set_vec(3'b001);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("r_load", remain, 1);
        chk("r_load_end", {g_end, y_end, r_end}, 0);
        repeat (3) step();
        chk("r_tick", tick, 1);
        chk("r_pre_end", r_end, 0);
        step();
        chk("r_end_pulse", {g_end, y_end, r_end}, 3'b001);
        chk("r_end_remain", remain, 0);
        step();
        chk("r_end_width", r_end, 0);
        chk("r_expired_remain", remain, 0);
        repeat (3) step();
        chk("r_expired_quiet", {g_end, y_end, r_end, tick}, 0);

        // green 3 s: 3->2->1->0 at load+4, +8, +12
        set_vec(3'b100);
        step();
        chk("g_load", remain, 3);
        for (int k = 1; k <= 13; k++) begin
            step();
            chk("g_remain", remain, (k >= 12) ? 0 : 3 - k / 4);
            chk("g_ends", {g_end, y_end, r_end}, (k == 12) ? 3'b100 : 3'b000);
        end

        // yellow 2 s with hold high over edges load+4..load+13
        set_vec(3'b010);
        step();
        chk("y_load", remain, 2);
        for (int k = 1; k <= 20; k++) begin
            step();
            held = HOLD_EN ? ((k <= 3) ? 0 : (k <= 13) ? k - 3 : 10) : 0;
            eff  = k - held;
            chk("y_remain", remain, (eff < 4) ? 2 : (eff < 8) ? 1 : 0);
            chk("y_ends", {g_end, y_end, r_end}, (eff == 8) ? 3'b010 : 3'b000);
            chk("y_tick", tick, ((eff % 4 == 3) && (eff < 8) && !(HOLD_EN && hold)) ? 1 : 0);
            if (k == 3) hold = 1'b1;
            if (k == 13) hold = 1'b0;
        end

        // phase change coinciding with the final tick of red
        set_vec(3'b001);
        step();
        chk("sim_load", remain, 1);
        repeat (3) step();
        chk("sim_tick", tick, 1);
        set_vec(3'b100);
        step();
        chk("sim_no_end", {g_end, y_end, r_end}, 0);
        chk("sim_reload", remain, 3);
        step();
        chk("sim_no_end_late", {g_end, y_end, r_end}, 0);

        // closed loop with a controller that advances on the edge after each end
        n_end = 0; multi = 0; phase_idx = 0; pending = 1'b0;
        set_vec(loop_vec(0));
        for (int c = 0; c < 300 && n_end < 7; c++) begin
            step();
            if (pending) begin
                phase_idx++;
                set_vec(loop_vec(phase_idx));
                pending = 1'b0;
            end
            if ($countones({g_end, y_end, r_end}) > 1) multi++;
            if (g_end || y_end || r_end) begin
                end_kind[n_end] = {g_end, y_end, r_end};
                end_cyc[n_end]  = cyc;
                n_end++;
                pending = 1'b1;
            end
        end
        chk("loop_ends_seen", n_end, 7);
        chk("loop_onehot", multi, 0);
        for (int i = 0; i < 7; i++) begin
            exp_vec = loop_vec(i);
            chk("loop_order", end_kind[i], exp_vec);
        end
        chk("loop_g_phase", end_cyc[1] - end_cyc[0], 14);
        chk("loop_full_cycle", end_cyc[6] - end_cyc[0], 60);

        // asynchronous reset mid-count
        set_vec(3'b100);
        step();
        repeat (5) step();
        chk("pre_rst_remain", remain, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_remain", remain, 0);
        chk("arst_ends", {g_end, y_end, r_end}, 0);
        chk("arst_tick", tick, 0);
        chk("arst_bcd", {tens, ones}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_reload", remain, 3);
        chk("arst_reload_ends", {g_end, y_end, r_end}, 0);

        // BCD, saturation, zero duration, non-one-hot vector
        {b_g, b_y, b_r} = 3'b100;
        @(negedge clk);
        rst_b = 1'b1;
        step();
        chk("b45_remain", b_remain, 45);
        chk("b45_bcd", {b_tens, b_ones}, 8'h45);
        repeat (4) step();
        chk("b44_remain", b_remain, 44);
        chk("b44_bcd", {b_tens, b_ones}, 8'h44);
        {b_g, b_y, b_r} = 3'b001;
        step();
        chk("b120_remain", b_remain, 120);
        chk("b120_bcd", {b_tens, b_ones}, 8'h99);
        {b_g, b_y, b_r} = 3'b010;
        step();
        chk("bzero_dur", b_remain, 1);
        chk("bzero_bcd", {b_tens, b_ones}, 8'h01);
        {b_g, b_y, b_r} = 3'b110;
        step();
        chk("bidle_remain", b_remain, 0);
        chk("bidle_bcd", {b_tens, b_ones}, 0);
        repeat (8) step();
        chk("bidle_quiet", {b_g_end, b_y_end, b_r_end, b_tick}, 0);
        chk("bidle_hold0", b_remain, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
